inst_fetch: RTL and testbench

Instruction fetch stage for the single-cycle CPU. It sits directly upstream of the `Control` decoder and the datapath. It owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds the instruction stable while the datapath executes it. On retire it computes the next PC from the datapath's branch/jump outcome.

---
 rtl/inst_fetch.sv | 102 ++++++++++
 tb/tb_inst_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: owns the PC, fetches over req/ack, holds inst during execute
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    EXEC     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_retire;

  assign w_fetch_done = (r_state == FETCH) && imem_ack;
  assign w_retire     = (r_state == EXEC) && retire;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  // Jump wins over a simultaneous taken branch.
  always_comb begin
    w_next_pc = w_pc4;
    if (jump)
      w_next_pc = {w_pc4[31:28], r_inst[25:0], 2'b00};
    else if (branch_taken)
      w_next_pc = w_pc4 + w_br_off;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RST_WAIT;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RST_WAIT: w_next_state = FETCH;
      FETCH:    if (imem_ack) w_next_state = EXEC;
      EXEC:     if (retire) w_next_state = FETCH;
      default:  w_next_state = RST_WAIT;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (r_state)
      FETCH:   imem_req = 1'b1;
      EXEC:    inst_valid = 1'b1;
      default: ;
    endcase
  end

  // PC is kept word-aligned even if RESET_PC is misconfigured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= {RESET_PC[31:2], 2'b00};
      r_inst    <= 32'd0;
      r_retired <= 32'd0;
    end else begin
      if (w_fetch_done)
        r_inst <= imem_rdata;
      if (w_retire) begin
        r_pc      <= {w_next_pc[31:2], 2'b00};
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign inst          = r_inst;
  assign opcode        = inst_valid ? r_inst[31:26] : 6'd0;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic        retire;
  logic        branch_taken;
  logic        jump;
  logic [31:0] retired_count;

  inst_fetch #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .opcode(opcode), .pc(pc),
    .retire(retire), .branch_taken(branch_taken), .jump(jump),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          lat;
    bit          taken;
    bit          jmp;
    bit          spur;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_q[$];
  logic [5:0]  op_q[$];
  logic [5:0]  cur_op;
  int          checks;
  int          failures;
  int          ret_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected fetch address on every accepted request.
  always @(negedge clk) begin
    chk("req_and_valid_exclusive", {31'd0, imem_req & inst_valid}, 32'd0);
    if (imem_req && imem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch actual=%h required=none", imem_addr);
      end else begin
        chk("fetch_addr", imem_addr, exp_q.pop_front());
        cur_op = (op_q.size() != 0) ? op_q.pop_front() : 6'd0;
      end
    end
    if (inst_valid)
      chk("opcode_exec", {26'd0, opcode}, {26'd0, cur_op});
    else
      chk("opcode_idle", {26'd0, opcode}, 32'd0);
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          ok;
    int          cnt;
    logic [31:0] w;
    w = v.word;
    wait_req(ok);
    chk("req_timeout", {31'd0, ok}, 32'd1);
    exp_q.push_back(v.addr);
    op_q.push_back(w[31:26]);
    cnt = 0;
    for (int i = 0; i <= v.lat; i++) begin
      if (imem_req) cnt++;
      imem_ack   = (i == v.lat);
      imem_rdata = (i == v.lat) ? w : 32'h0;
      if (v.spur && i == 0) begin
        retire = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      end
      @(posedge clk); #1;
      retire = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      if (v.spur && i == 0) begin
        chk("spur_retire_count", retired_count, ret_exp);
        chk("spur_retire_pc", pc, v.addr);
        chk("spur_retire_req", {31'd0, imem_req}, 32'd1);
      end
    end
    imem_ack = 1'b0;
    chk("fetch_cycles", cnt, v.lat + 1);
    chk("exec_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_req_low", {31'd0, imem_req}, 32'd0);
    chk("exec_inst", inst, w);
    if (v.spur) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (v.spur) begin
      chk("spur_ack_inst", inst, w);
      chk("spur_ack_valid", {31'd0, inst_valid}, 32'd1);
      chk("spur_ack_pc", pc, v.addr);
    end
    retire = 1'b1; branch_taken = v.taken; jump = v.jmp;
    @(posedge clk); #1;
    retire = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    ret_exp++;
    chk("retired_count", retired_count, ret_exp);
    chk("retire_valid_low", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    checks = 0; failures = 0; ret_exp = 0; cur_op = 6'd0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    retire = 1'b0; branch_taken = 1'b0; jump = 1'b0;

    vecs[0] = '{32'h0000_0040, 32'h8C01_0000, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0044, 32'hAC01_0004, 3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0048, 32'h0800_0040, 0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'h1000_FFFF, 1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0100, 32'h1000_FFBE, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0020, 2, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0BFF_FFFE, 0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0FFF_FFF8, 32'h1000_0005, 0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h1000_0010, 32'h0800_0020, 0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h40);
    chk("rst_addr", imem_addr, 32'h40);
    chk("rst_inst", inst, 32'h0);
    chk("rst_count", retired_count, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);

    rst = 1'b0;
    chk("rst_wait_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h40);

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i]);

    // Reset while FETCH has a live ack: the ack must be discarded.
    wait_req(ok);
    chk("req_timeout", {31'd0, ok}, 32'd1);
    exp_q.push_back(32'h1000_0080);
    op_q.push_back(6'd0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C00_1234;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("midrst_pc", pc, 32'h40);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_count", retired_count, 32'h0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h40);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
